// File: rtl/a2d_pkg.sv
// ---------------------------------------------------------------------------
// a2d_pkg
// Shared types and constants for the A2D channel scheduler.
//   state_t     : scheduler FSM states
//   chnl_idx_t  : position within a conversion round (0..3)
//   CMD_PFX     : upper two bits of every channel-select command
//   CH_*        : A2D mux channel numbers in round order
//   chnl_cmd()  : builds the channel-select command for a round position
// ---------------------------------------------------------------------------
package a2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT_CMD,
    GAP,
    READ,
    WAIT_RD,
    GAP2
  } state_t;

  typedef logic [1:0] chnl_idx_t;

  localparam logic [1:0] CMD_PFX  = 2'b00;

  localparam logic [2:0] CH_LFT   = 3'd0;
  localparam logic [2:0] CH_RGHT  = 3'd4;
  localparam logic [2:0] CH_STEER = 3'd5;
  localparam logic [2:0] CH_BATT  = 3'd6;

  // Round position -> channel-select command word.
  function automatic logic [15:0] chnl_cmd(chnl_idx_t idx);
    logic [2:0] ch;
    case (idx)
      2'd0:    ch = CH_LFT;
      2'd1:    ch = CH_RGHT;
      2'd2:    ch = CH_STEER;
      default: ch = CH_BATT;
    endcase
    return {CMD_PFX, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_chnl_sched_if.sv
// ---------------------------------------------------------------------------
// a2d_chnl_sched_if
// Transaction handshake between the A2D scheduler and the SPI master.
//   spi_wrt  : one-clock launch pulse (scheduler -> SPI master)
//   spi_cmd  : 16-bit command word, stable from spi_wrt until spi_done
//   spi_done : one-clock completion pulse (SPI master -> scheduler)
//   spi_rd   : 16-bit returned data, valid in the spi_done cycle
// master modport = scheduler side, slave modport = SPI master side.
// ---------------------------------------------------------------------------
interface a2d_chnl_sched_if;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd;

  modport master (output spi_wrt, output spi_cmd, input spi_done, input spi_rd);
  modport slave  (input spi_wrt, input spi_cmd, output spi_done, output spi_rd);
endinterface

// File: rtl/a2d_gap_tmr.sv
// ---------------------------------------------------------------------------
// a2d_gap_tmr
// Loadable down-counter shared by the settling gap and the SPI timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this clock (takes priority over counting)
//   load_val   : value loaded; terminal count follows load_val clocks later
//   tc         : high while the count is zero (counter holds at zero)
// ---------------------------------------------------------------------------
module a2d_gap_tmr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign tc = (cnt_reg == '0);

endmodule

// File: rtl/a2d_chnl_sched.sv
// ---------------------------------------------------------------------------
// a2d_chnl_sched
// Round-robin A2D scheduler: each round converts LFT, RGHT, STEER, BATT,
// each as a channel-select SPI transaction followed by a read transaction,
// with GAP_CYC idle clocks between a done and the next launch, and a
// TMO_CYC-clock guard against a hung SPI master.
//   clk, rst_n   : clock, asynchronous active-low reset
//   nxt          : one-clock request for a conversion round
//   spi          : SPI master handshake (master modport)
//   lft_ld, rght_ld, steer_pot, batt : latched 12-bit results
//   busy         : high whenever the FSM is outside IDLE
//   round_vld    : one-clock pulse, all four results of a round updated
//   tmo_err      : one-clock pulse, round aborted on SPI timeout
// ---------------------------------------------------------------------------
module a2d_chnl_sched
  import a2d_pkg::*;
#(
  parameter int unsigned GAP_CYC = 8,
  parameter int unsigned TMO_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    nxt,
  a2d_chnl_sched_if.master        spi,
  output logic [11:0]             lft_ld,
  output logic [11:0]             rght_ld,
  output logic [11:0]             steer_pot,
  output logic [11:0]             batt,
  output logic                    busy,
  output logic                    round_vld,
  output logic                    tmo_err
);

  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYC - 1);
  localparam logic [15:0] TMO_LOAD = 16'(TMO_CYC - 1);

  state_t      state_reg, state_next;
  chnl_idx_t   idx_reg, idx_next;
  logic        pend_reg;
  logic        was_idle_reg;
  logic        wrt_reg;
  logic [15:0] cmd_reg;
  logic        rv_reg;

  logic        cap;
  logic        rnd_end;
  logic        tmo_hit;
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_tc;

  // Timer is loaded on entry to any counted state; in the wait states its
  // terminal count lands TMO_CYC clocks after the launching spi_wrt.
  always_comb begin
    tmr_load = (state_next != state_reg) &&
               (state_next inside {WAIT_CMD, WAIT_RD, GAP, GAP2});
    tmr_val  = (state_next == WAIT_CMD || state_next == WAIT_RD) ? TMO_LOAD : GAP_LOAD;
  end

  a2d_gap_tmr #(.W(16)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Next-state logic. spi_done is checked before the timeout so a done in
  // the terminal-count cycle is honoured.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cap        = 1'b0;
    rnd_end    = 1'b0;
    tmo_hit    = 1'b0;
    case (state_reg)
      // A pending request waits one extra IDLE clock after a round ends so
      // busy is seen low between back-to-back rounds.
      IDLE:     if (nxt || (pend_reg && was_idle_reg)) state_next = CMD;
      CMD:      state_next = WAIT_CMD;
      WAIT_CMD: begin
        if (spi.spi_done) begin
          state_next = GAP;
        end else if (tmr_tc) begin
          tmo_hit    = 1'b1;
          idx_next   = '0;
          state_next = IDLE;
        end
      end
      GAP:      if (tmr_tc) state_next = READ;
      READ:     state_next = WAIT_RD;
      WAIT_RD: begin
        if (spi.spi_done) begin
          cap = 1'b1;
          if (idx_reg == 2'd3) begin
            idx_next   = '0;
            rnd_end    = 1'b1;
            state_next = IDLE;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = GAP2;
          end
        end else if (tmr_tc) begin
          tmo_hit    = 1'b1;
          idx_next   = '0;
          state_next = IDLE;
        end
      end
      GAP2:     if (tmr_tc) state_next = CMD;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      pend_reg     <= 1'b0;
      was_idle_reg <= 1'b1;
      wrt_reg      <= 1'b0;
      cmd_reg      <= '0;
      rv_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      was_idle_reg <= (state_reg == IDLE);
      // Single-depth request memory; extra requests during a round merge.
      if (state_reg == IDLE && state_next == CMD) begin
        pend_reg <= 1'b0;
      end else if (nxt && state_reg != IDLE) begin
        pend_reg <= 1'b1;
      end
      wrt_reg <= (state_next == CMD) || (state_next == READ);
      // Command word changes only at launch, so it is stable until done.
      if (state_next == CMD) begin
        cmd_reg <= chnl_cmd(idx_reg);
      end else if (state_next == READ) begin
        cmd_reg <= '0;
      end
      rv_reg <= rnd_end;
    end
  end

  // One result register per round position, written only at its own read.
  for (genvar gi = 0; gi < 4; gi++) begin : g_res
    logic [11:0] val_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_reg <= '0;
      end else if (cap && idx_reg == chnl_idx_t'(gi)) begin
        val_reg <= spi.spi_rd[11:0];
      end
    end
  end

  assign lft_ld      = g_res[0].val_reg;
  assign rght_ld     = g_res[1].val_reg;
  assign steer_pot   = g_res[2].val_reg;
  assign batt        = g_res[3].val_reg;
  assign busy        = (state_reg != IDLE);
  assign round_vld   = rv_reg;
  assign tmo_err     = tmo_hit;
  assign spi.spi_wrt = wrt_reg;
  assign spi.spi_cmd = cmd_reg;

endmodule

// File: tb/tb_a2d_chnl_sched.sv
// ---------------------------------------------------------------------------
// tb_a2d_chnl_sched
// Self-checking bench for a2d_chnl_sched. A behavioural SPI/A2D model
// answers each launch after a programmable delay (returning the value of the
// last selected channel on reads). Expected commands and round results are
// queued when a round is requested and compared as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_a2d_chnl_sched;

  localparam int GAP = 8;
  localparam int TMO = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        busy, round_vld, tmo_err;

  a2d_chnl_sched_if spi_if ();

  a2d_chnl_sched #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxt       (nxt),
    .spi       (spi_if),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .busy      (busy),
    .round_vld (round_vld),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- SPI / A2D model ----------------
  logic [15:0] chan_val [8];
  int          done_dly = 3;
  int          txn_no = 0;
  int          drop_at = -1;
  int          sp_at = -1;
  int          sp_dly = 0;
  int          m_cnt = 0;
  bit          m_phase = 1'b0;
  logic [2:0]  m_ch = 3'd0;
  logic [15:0] m_resp = 16'h0;

  initial begin
    spi_if.spi_done = 1'b0;
    spi_if.spi_rd   = 16'h0;
    forever begin
      @(posedge clk); #1;
      spi_if.spi_done = 1'b0;
      if (!busy) m_phase = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          spi_if.spi_done = 1'b1;
          spi_if.spi_rd   = m_resp;
        end
      end
      if (spi_if.spi_wrt) begin
        txn_no++;
        if (!m_phase) begin
          m_ch    = spi_if.spi_cmd[13:11];
          m_resp  = 16'hEEEE;
          m_phase = 1'b1;
        end else begin
          m_resp  = chan_val[m_ch];
          m_phase = 1'b0;
        end
        if (txn_no == drop_at)    m_cnt = 0;
        else if (txn_no == sp_at) m_cnt = sp_dly;
        else                      m_cnt = done_dly;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [15:0] cmd_tbl [8] = '{16'h0000, 16'h0000, 16'h2000, 16'h0000,
                               16'h2800, 16'h0000, 16'h3000, 16'h0000};
  logic [15:0] cmd_q [$];
  logic [47:0] res_q [$];
  int n_rv = 0, n_tmo = 0, n_wrt = 0;
  int last_wrt_cyc = 0, last_done_cyc = 0, last_rv_cyc = 0;
  int tmo_dist = -1, rv_wrt_dist = -1, nxt_cyc = 0;
  bit gap_armed = 1'b0, rv_watch = 1'b0, lat_armed = 1'b0;

  initial begin
    logic [15:0] e_cmd;
    logic [47:0] e_res;
    forever begin
      @(negedge clk);
      if (!busy) gap_armed = 1'b0;
      if (spi_if.spi_wrt) begin
        n_wrt++;
        if (cmd_q.size() == 0) begin
          chk_eq("unexp_wrt", 32'(spi_if.spi_wrt), 32'd0);
        end else begin
          e_cmd = cmd_q.pop_front();
          chk_eq("spi_cmd", 32'(spi_if.spi_cmd), 32'(e_cmd));
        end
        if (gap_armed) chk_eq("gap_len", 32'(cyc - last_done_cyc), 32'(GAP + 1));
        if (lat_armed) begin
          chk_eq("nxt_lat", 32'(cyc - nxt_cyc), 32'd1);
          lat_armed = 1'b0;
        end
        if (rv_watch) begin
          rv_wrt_dist = cyc - last_rv_cyc;
          rv_watch = 1'b0;
        end
        last_wrt_cyc = cyc;
      end
      if (spi_if.spi_done) begin
        if (busy) gap_armed = 1'b1;
        last_done_cyc = cyc;
      end
      if (round_vld) begin
        n_rv++;
        last_rv_cyc = cyc;
        rv_watch = 1'b1;
        chk_eq("rv_lat", 32'(cyc - last_done_cyc), 32'd1);
        if (res_q.size() == 0) begin
          chk_eq("unexp_rv", 32'(round_vld), 32'd0);
        end else begin
          e_res = res_q.pop_front();
          chk_eq("rv_lft",   32'(lft_ld),    32'(e_res[47:36]));
          chk_eq("rv_rght",  32'(rght_ld),   32'(e_res[35:24]));
          chk_eq("rv_steer", 32'(steer_pot), 32'(e_res[23:12]));
          chk_eq("rv_batt",  32'(batt),      32'(e_res[11:0]));
        end
      end
      if (tmo_err) begin
        n_tmo++;
        tmo_dist = cyc - last_wrt_cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input logic [15:0] l, input logic [15:0] r,
                          input logic [15:0] s, input logic [15:0] b);
    chan_val[0] = l; chan_val[4] = r; chan_val[5] = s; chan_val[6] = b;
  endtask

  task automatic start_round(input logic [11:0] l, input logic [11:0] r,
                             input logic [11:0] s, input logic [11:0] b,
                             input int n_cmds, input bit push_res, input bit timed);
    for (int i = 0; i < n_cmds; i++) cmd_q.push_back(cmd_tbl[i]);
    if (push_res) res_q.push_back({l, r, s, b});
    nxt = 1'b1;
    nxt_cyc = cyc;
    lat_armed = timed;
    tick(1);
    nxt = 1'b0;
  endtask

  task automatic wait_rv(input int target, input int budget, input string tag);
    int k = 0;
    while (n_rv < target && k < budget) begin
      tick(1);
      k++;
    end
    chk_eq(tag, 32'(n_rv), 32'(target));
  endtask

  task automatic chk_res(input string tag, input logic [11:0] l, input logic [11:0] r,
                         input logic [11:0] s, input logic [11:0] b);
    chk_eq({tag, "_lft"},   32'(lft_ld),    32'(l));
    chk_eq({tag, "_rght"},  32'(rght_ld),   32'(r));
    chk_eq({tag, "_steer"}, 32'(steer_pot), 32'(s));
    chk_eq({tag, "_batt"},  32'(batt),      32'(b));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base, base_tmo, t0, k, wrt_before;
    for (int i = 0; i < 8; i++) chan_val[i] = 16'h0;
    rst_n = 1'b0;
    tick(3);
    chk_res("rst", 12'h0, 12'h0, 12'h0, 12'h0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_rv", 32'(round_vld), 32'd0);
    chk_eq("rst_tmo", 32'(tmo_err), 32'd0);
    chk_eq("rst_wrt", 32'(spi_if.spi_wrt), 32'd0);
    chk_eq("rst_cmd", 32'(spi_if.spi_cmd), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: basic round, command sequence and results
    done_dly = 3;
    set_vals(16'h0123, 16'h0456, 16'h0789, 16'h0ABC);
    base = n_rv;
    start_round(12'h123, 12'h456, 12'h789, 12'hABC, 8, 1'b1, 1'b1);
    wait_rv(base + 1, 2000, "t1_rv");
    tick(20);
    chk_eq("t1_rv_once", 32'(n_rv), 32'(base + 1));
    chk_res("t1", 12'h123, 12'h456, 12'h789, 12'hABC);
    chk_eq("t1_busy", 32'(busy), 32'd0);

    // 2: timing with a 40-clock SPI master; upper data bits must be dropped
    done_dly = 40;
    set_vals(16'hF111, 16'hE222, 16'hD333, 16'hC444);
    base = n_rv;
    start_round(12'h111, 12'h222, 12'h333, 12'h444, 8, 1'b1, 1'b1);
    wait_rv(base + 1, 2000, "t2_rv");
    tick(10);

    // 3: third transaction never completes -> timeout
    set_vals(16'h5AAA, 16'h5BBB, 16'h5CCC, 16'h5DDD);
    base = n_rv;
    base_tmo = n_tmo;
    drop_at = txn_no + 3;
    start_round(12'h0, 12'h0, 12'h0, 12'h0, 3, 1'b0, 1'b1);
    k = 0;
    while (n_tmo == base_tmo && k < 6000) begin
      tick(1);
      k++;
    end
    chk_eq("t3_tmo", 32'(n_tmo), 32'(base_tmo + 1));
    chk_eq("t3_tmo_lat", 32'(tmo_dist), 32'(TMO));
    chk_eq("t3_busy_fall", 32'(busy), 32'd0);
    tick(50);
    chk_res("t3", 12'hAAA, 12'h222, 12'h333, 12'h444);
    chk_eq("t3_no_rv", 32'(n_rv), 32'(base));
    chk_eq("t3_single_tmo", 32'(n_tmo), 32'(base_tmo + 1));
    drop_at = -1;

    // 4: three requests mid-round merge into one extra round
    set_vals(16'h0321, 16'h0654, 16'h0987, 16'h0CBA);
    base = n_rv;
    rv_wrt_dist = -1;
    start_round(12'h321, 12'h654, 12'h987, 12'hCBA, 8, 1'b1, 1'b1);
    tick(100);
    start_round(12'h321, 12'h654, 12'h987, 12'hCBA, 8, 1'b1, 1'b0);
    tick(30);
    nxt = 1'b1; tick(1); nxt = 1'b0;
    tick(30);
    nxt = 1'b1; tick(1); nxt = 1'b0;
    wait_rv(base + 2, 4000, "t4_rv");
    tick(200);
    chk_eq("t4_rounds", 32'(n_rv), 32'(base + 2));
    chk_eq("t4_restart", 32'(rv_wrt_dist), 32'd2);
    chk_eq("t4_q_empty", 32'(cmd_q.size()), 32'd0);

    // 5: reset during the STEER read
    set_vals(16'h0111, 16'h0222, 16'h0333, 16'h0444);
    t0 = txn_no;
    start_round(12'h111, 12'h222, 12'h333, 12'h444, 8, 1'b1, 1'b1);
    k = 0;
    while (txn_no < t0 + 6 && k < 2000) begin
      tick(1);
      k++;
    end
    chk_eq("t5_reach_rd2", 32'(txn_no >= t0 + 6), 32'd1);
    tick(5);
    rst_n = 1'b0;
    #1;
    chk_res("t5_rst", 12'h0, 12'h0, 12'h0, 12'h0);
    chk_eq("t5_rst_busy", 32'(busy), 32'd0);
    cmd_q.delete();
    res_q.delete();
    lat_armed = 1'b0;
    tick(2);
    rst_n = 1'b1;
    wrt_before = n_wrt;
    tick(60);
    chk_eq("t5_no_wrt", 32'(n_wrt), 32'(wrt_before));
    chk_res("t5_hold", 12'h0, 12'h0, 12'h0, 12'h0);
    base = n_rv;
    set_vals(16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04);
    start_round(12'hA01, 12'hA02, 12'hA03, 12'hA04, 8, 1'b1, 1'b1);
    wait_rv(base + 1, 2000, "t5_rv");
    tick(10);

    // 6: done arrives in the timeout terminal-count cycle
    set_vals(16'h0B01, 16'h0B02, 16'h0B03, 16'h0B04);
    base = n_rv;
    base_tmo = n_tmo;
    sp_at = txn_no + 4;
    sp_dly = TMO;
    start_round(12'hB01, 12'hB02, 12'hB03, 12'hB04, 8, 1'b1, 1'b1);
    wait_rv(base + 1, 8000, "t6_rv");
    tick(10);
    chk_eq("t6_no_tmo", 32'(n_tmo), 32'(base_tmo));
    chk_res("t6", 12'hB01, 12'hB02, 12'hB03, 12'hB04);
    sp_at = -1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
